// File: rtl/sound_ram_arbiter.sv
// sound_ram_arbiter
//   Shares the sound-board work RAM between the sound CPU and a host port
//   (loader / debug / save-state). Grants alternate between the two ports,
//   and each grant occupies the RAM for three clocks:
//     - issue
//     - wait for the RAM's registered read data
//     - capture and acknowledge
//   A clear engine fills the whole RAM with CLEAR_VALUE after reset (when
//   CLEAR_ON_RESET is set) or on request. While it runs, both requesters
//   are held off.
//
// Ports
//   clk, reset_n               system clock, asynchronous active-low reset
//   cpu_req/we/addr/din        CPU request (level, held until cpu_ack)
//   cpu_dout, cpu_ack          CPU read data and one-cycle completion pulse
//   host_req/we/addr/din       host request, same protocol as the CPU port
//   host_dout, host_ack        host read data and completion pulse
//   clear_req                  one-cycle pulse that starts a full RAM clear
//   clear_busy                 high while the clear engine owns the RAM
//   ram_address/write/data     registered RAM address, write enable and data
//   ram_q                      registered (read-first) RAM read data

module sound_ram_arbiter #(
  parameter int unsigned       ADDR_W         = 11,
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  output logic              host_ack,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t            state, state_next;
  // The extra top bit marks "last address already written".
  logic [ADDR_W:0]   clear_cnt, clear_cnt_next;
  logic              clear_pending, clear_pending_next;
  logic              last_host, last_host_next;
  logic              owner_host, owner_host_next;
  logic [ADDR_W-1:0] ram_address_next;
  logic              ram_write_next;
  logic [DATA_W-1:0] ram_data_next;
  logic [DATA_W-1:0] cpu_dout_next, host_dout_next;
  logic              cpu_ack_next, host_ack_next;
  logic              clear_busy_next;

  logic cpu_elig, host_elig, grant_host;

  // A port that is being acknowledged this cycle is not eligible for a new
  // grant. On a tie, the grant goes to the port that was not served last.
  assign cpu_elig   = cpu_req & ~cpu_ack;
  assign host_elig  = host_req & ~host_ack;
  assign grant_host = host_elig & (~cpu_elig | ~last_host);

  // State and output registers; every RAM-facing signal is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_STATE;
      clear_cnt     <= '0;
      clear_pending <= 1'b0;
      last_host     <= 1'b0;
      owner_host    <= 1'b0;
      ram_address   <= '0;
      ram_write     <= 1'b0;
      ram_data      <= '0;
      cpu_dout      <= '0;
      host_dout     <= '0;
      cpu_ack       <= 1'b0;
      host_ack      <= 1'b0;
      clear_busy    <= 1'b0;
    end else begin
      state         <= state_next;
      clear_cnt     <= clear_cnt_next;
      clear_pending <= clear_pending_next;
      last_host     <= last_host_next;
      owner_host    <= owner_host_next;
      ram_address   <= ram_address_next;
      ram_write     <= ram_write_next;
      ram_data      <= ram_data_next;
      cpu_dout      <= cpu_dout_next;
      host_dout     <= host_dout_next;
      cpu_ack       <= cpu_ack_next;
      host_ack      <= host_ack_next;
      clear_busy    <= clear_busy_next;
    end
  end

  // Next-state logic and next register values. Acks are single-cycle
  // pulses, so they default low. All other registers hold by default.
  always_comb begin
    state_next         = state;
    clear_cnt_next     = clear_cnt;
    clear_pending_next = clear_pending;
    last_host_next     = last_host;
    owner_host_next    = owner_host;
    ram_address_next   = ram_address;
    ram_write_next     = ram_write;
    ram_data_next      = ram_data;
    cpu_dout_next      = cpu_dout;
    host_dout_next     = host_dout;
    cpu_ack_next       = 1'b0;
    host_ack_next      = 1'b0;
    clear_busy_next    = clear_busy;

    case (state)
      ST_CLEAR: begin
        clear_pending_next = 1'b0;
        if (clear_req) begin
          // A new clear request restarts the sweep from address 0.
          ram_address_next = '0;
          ram_write_next   = 1'b1;
          ram_data_next    = CLEAR_VALUE;
          clear_busy_next  = 1'b1;
          clear_cnt_next   = (ADDR_W+1)'(1);
        end else if (clear_cnt[ADDR_W]) begin
          ram_write_next  = 1'b0;
          clear_busy_next = 1'b0;
          state_next      = ST_IDLE;
        end else begin
          ram_address_next = clear_cnt[ADDR_W-1:0];
          ram_write_next   = 1'b1;
          ram_data_next    = CLEAR_VALUE;
          clear_busy_next  = 1'b1;
          clear_cnt_next   = clear_cnt + (ADDR_W+1)'(1);
        end
      end

      ST_IDLE: begin
        if (clear_req || clear_pending) begin
          clear_pending_next = 1'b0;
          clear_cnt_next     = '0;
          state_next         = ST_CLEAR;
        end else if (cpu_elig || host_elig) begin
          ram_address_next = grant_host ? host_addr : cpu_addr;
          ram_data_next    = grant_host ? host_din  : cpu_din;
          ram_write_next   = grant_host ? host_we   : cpu_we;
          owner_host_next  = grant_host;
          last_host_next   = grant_host;
          state_next       = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        ram_write_next = 1'b0;
        if (clear_req) clear_pending_next = 1'b1;
        state_next = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // ram_q now holds the addressed word (its old value on a write).
        if (owner_host) begin
          host_dout_next = ram_q;
          host_ack_next  = 1'b1;
        end else begin
          cpu_dout_next = ram_q;
          cpu_ack_next  = 1'b1;
        end
        if (clear_req) clear_pending_next = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// tb_sound_ram_arbiter
//   Directed and randomized checks for sound_ram_arbiter. The bench contains
//   a behavioural RAM (registered, read-first) and a shadow copy of the
//   expected RAM contents. The shadow is updated in completion order.
//
// Ports: none (top-level bench).

module tb_sound_ram_arbiter;

  localparam int         ADDR_W      = 11;
  localparam int         DATA_W      = 8;
  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [7:0] CLEAR_VALUE = 8'h00;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_req, cpu_we, host_req, host_we, clear_req;
  logic [ADDR_W-1:0] cpu_addr, host_addr;
  logic [DATA_W-1:0] cpu_din, host_din;
  logic [DATA_W-1:0] cpu_dout, host_dout;
  logic              cpu_ack, host_ack, clear_busy;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] mem    [0:DEPTH-1];
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  bit                last_host;
  int                n_compared  = 0;
  int                n_mismatched = 0;

  sound_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLEAR_VALUE(CLEAR_VALUE), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_dout(host_dout), .host_ack(host_ack),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .ram_address(ram_address), .ram_write(ram_write), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Registered read-first RAM: q shows the old word even on a write.
  always @(posedge clk) begin
    ram_q <= mem[ram_address];
    if (ram_write) mem[ram_address] <= ram_data;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
    if (p == 1) begin
      host_req = req; host_we = we; host_addr = addr; host_din = din;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_din = din;
    end
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < DEPTH; i++) shadow[i] = CLEAR_VALUE;
  endtask

  // Follow one complete clear sweep: every busy cycle must write
  // CLEAR_VALUE to the next address, starting at 0.
  task automatic expect_clear(input string tag);
    int   busy_cycles = 0;
    int   seq_errors  = 0;
    int   acks_seen   = 0;
    bit   seen        = 1'b0;
    logic end_write   = 1'bx;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) acks_seen++;
      if (clear_busy) begin
        seen = 1'b1;
        if (ram_write !== 1'b1 || ram_address !== ADDR_W'(busy_cycles) ||
            ram_data !== CLEAR_VALUE) seq_errors++;
        busy_cycles++;
      end else if (seen) begin
        end_write = ram_write;
        break;
      end
    end
    check_output({tag, "_busy_cycles"}, busy_cycles, DEPTH);
    check_output({tag, "_sequence"}, seq_errors, 0);
    check_output({tag, "_no_ack"}, acks_seen, 0);
    check_output({tag, "_end_write"}, {31'b0, end_write}, 0);
    reset_shadow();
  endtask

  // One access from an idle arbiter. It checks the three-cycle latency,
  // that the returned data is the pre-access RAM word, and that the write
  // strobe lasts exactly one cycle on a write. It can optionally pulse
  // clear_req while the access is in flight.
  task automatic apply_access(input string tag, input int p, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din,
                              input bit pulse_clear);
    int               lat = 0;
    int               wr_cycles = 0;
    int               other_acks = 0;
    logic [DATA_W-1:0] dout = 'x;
    @(negedge clk);
    drive(p, 1'b1, we, addr, din);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (ram_write) wr_cycles++;
      if ((p == 1) ? cpu_ack : host_ack) other_acks++;
      if (pulse_clear) clear_req = (lat == 1);
      if ((p == 1) ? host_ack : cpu_ack) begin
        dout = (p == 1) ? host_dout : cpu_dout;
        break;
      end
    end
    clear_req = 1'b0;
    drive(p, 1'b0, 1'b0, '0, '0);
    check_output({tag, "_latency"}, lat, 3);
    check_output({tag, "_dout"}, dout, shadow[addr]);
    check_output({tag, "_write_cycles"}, wr_cycles, {31'b0, we});
    check_output({tag, "_other_ack"}, other_acks, 0);
    if (we) shadow[addr] = din;
    last_host = (p == 1);
  endtask

  // Random traffic on both ports. Each port holds its request until it is
  // acknowledged. Every acknowledge is checked against the shadow memory.
  // A waiting port may see at most one access of the other port before
  // it is served. If check_alt is set, every grant must go to the port
  // that was not served last.
  task automatic apply_stimulus(input string tag, input int cycles, input int pct,
                                input bit check_alt, input int addr_max);
    bit                pend [2];
    logic              we   [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] din  [2];
    int                wait_other [2];
    int                age [2];
    int                dual = 0, spurious = 0, timeouts = 0;
    logic              ack;
    logic [DATA_W-1:0] dout;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; wait_other[p] = 0; age[p] = 0;
    end
    for (int c = 0; c < cycles + 200; c++) begin
      @(negedge clk);
      if (cpu_ack && host_ack) dual++;
      for (int p = 0; p < 2; p++) begin
        ack  = (p == 1) ? host_ack  : cpu_ack;
        dout = (p == 1) ? host_dout : cpu_dout;
        if (ack) begin
          if (!pend[p]) spurious++;
          else begin
            check_output({tag, "_dout"}, dout, shadow[addr[p]]);
            check_output({tag, "_wait_bound"}, {31'b0, wait_other[p] <= 1}, 1);
            if (check_alt) check_output({tag, "_order"}, p, {31'b0, ~last_host});
            if (we[p]) shadow[addr[p]] = din[p];
            last_host = (p == 1);
            pend[p] = 1'b0;
            if (pend[1-p]) wait_other[1-p]++;
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 40) begin
            timeouts++;
            pend[p] = 1'b0;
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (c < cycles && !pend[p] && $urandom_range(99) < pct) begin
          pend[p] = 1'b1; age[p] = 0; wait_other[p] = 0;
          we[p]   = 1'($urandom_range(1));
          addr[p] = ADDR_W'($urandom_range(addr_max - 1));
          din[p]  = DATA_W'($urandom);
          drive(p, 1'b1, we[p], addr[p], din[p]);
        end
      end
      if (c >= cycles && !pend[0] && !pend[1]) break;
    end
    if (pend[0] || pend[1]) timeouts++;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check_output({tag, "_dual_ack"}, dual, 0);
    check_output({tag, "_spurious_ack"}, spurious, 0);
    check_output({tag, "_timeouts"}, timeouts, 0);
  endtask

  initial begin
    int   b, exp_addr, seq_err, ack_during, idle_cycles, ack_at;
    logic [DATA_W-1:0] ack_dout;

    // Power-on reset: all outputs must be low.
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_din = '0;
    clear_req = 0;
    last_host = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_acks", {30'b0, cpu_ack, host_ack}, 0);
    check_output("reset_douts", {16'b0, cpu_dout, host_dout}, 0);
    check_output("reset_busy", {31'b0, clear_busy}, 0);
    check_output("reset_ram_ctl", {20'b0, ram_write, ram_address}, 0);
    check_output("reset_ram_data", {24'b0, ram_data}, 0);
    reset_n = 1'b1;
    expect_clear("por_clear");

    // CPU write followed by a read-back of the same address.
    apply_access("cpu_write", 0, 1'b1, 11'h123, 8'h5A, 1'b0);
    apply_access("cpu_read", 0, 1'b0, 11'h123, 8'h00, 1'b0);

    // Both ports requesting continuously must alternate, host first.
    apply_stimulus("alternate", 24, 100, 1'b1, 16);

    // Mixed random traffic.
    apply_stimulus("random", 400, 40, 1'b0, 16);

    // A clear requested during a CPU read lets the read finish first.
    apply_access("host_seed", 1, 1'b1, 11'h200, 8'hC3, 1'b0);
    apply_access("cpu_read_clr", 0, 1'b0, 11'h200, 8'h00, 1'b1);
    check_output("busy_at_ack", {31'b0, clear_busy}, 0);
    expect_clear("mid_access_clear");
    apply_access("host_after_clr", 1, 1'b0, 11'h200, 8'h00, 1'b0);

    // A host request raised during a clear is served only afterwards.
    // A second clear_req mid-sweep restarts the sweep at address 0.
    @(negedge clk) clear_req = 1'b1;
    @(negedge clk) clear_req = 1'b0;
    b = 0; exp_addr = 0; seq_err = 0; ack_during = 0; idle_cycles = 0; ack_at = -1;
    ack_dout = 'x;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (clear_busy) begin
        b++;
        if (host_ack) ack_during++;
        if (ram_write !== 1'b1 || ram_address !== ADDR_W'(exp_addr)) seq_err++;
        exp_addr++;
        if (b == 100) drive(1, 1'b1, 1'b0, 11'h055, 8'h00);
        if (b == 500) begin
          clear_req = 1'b1;
          exp_addr  = 0;
        end else clear_req = 1'b0;
      end else if (b > 0) begin
        idle_cycles++;
        if (host_ack) begin
          ack_at   = idle_cycles;
          ack_dout = host_dout;
          break;
        end
      end
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    reset_shadow();
    last_host = 1'b1;
    check_output("restart_busy_cycles", b, 500 + DEPTH);
    check_output("restart_sequence", seq_err, 0);
    check_output("host_ack_in_clear", ack_during, 0);
    check_output("host_ack_after_idle", ack_at - 1, 3);
    check_output("host_dout_after_clear", ack_dout, shadow[11'h055]);

    // An asynchronous reset during an access clears the outputs at once,
    // abandons the access, and restarts the clear.
    @(negedge clk) drive(0, 1'b1, 1'b1, 11'h300, 8'h77);
    @(negedge clk);
    check_output("pre_reset_write", {31'b0, ram_write}, 1);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_ram", {12'b0, ram_write, ram_address, ram_data}, 0);
    check_output("async_reset_flags", {29'b0, cpu_ack, host_ack, clear_busy}, 0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b1;
    last_host = 1'b0;
    expect_clear("reset_clear");
    apply_access("cpu_read_300", 0, 1'b0, 11'h300, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
